// File: rtl/nios2_ls_p_counter_trigger.sv
// nios2_ls_p_counter_trigger
// Avalon-MM write master that turns datapath start/stop/clear pulses into
// control writes for the section performance counter, so sections can be
// timed without any software involvement.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no write on the bus; arbitrate pending commands each cycle
//   ST_WRITE | write on the bus; hold outputs until m_waitrequest is low
//
// Command map: stop n -> word 4n, start n -> word 4n+1 (data 0),
//              clear  -> word 0 with data 32'h1.
module nios2_ls_p_counter_trigger #(
  parameter int NUM_SECTIONS = 8,
  parameter int DROP_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SECTIONS-1:0] evt_start,
  input  logic [NUM_SECTIONS-1:0] evt_stop,
  input  logic                    evt_clear,
  output logic [4:0]              m_address,
  output logic                    m_write,
  output logic                    m_begintransfer,
  output logic [31:0]             m_writedata,
  input  logic                    m_waitrequest,
  output logic                    busy,
  output logic [DROP_W-1:0]       dropped_count
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // Wide enough to add up to 2*NUM_SECTIONS+1 drops without wrapping.
  localparam int SUM_W = DROP_W + 5;

  logic [0:0]              state;

  logic [NUM_SECTIONS-1:0] pend_start;
  logic [NUM_SECTIONS-1:0] pend_stop;
  // 1: start was captured before stop for that section (start goes first).
  logic [NUM_SECTIONS-1:0] start_first;
  logic                    pend_clear;

  logic                    sec_found;
  logic                    any_pend;
  logic                    sel_clear;
  logic                    sel_is_start;
  logic [2:0]              sel_sec;
  logic [NUM_SECTIONS-1:0] sec_onehot;
  logic [4:0]              sel_addr;
  logic [31:0]             sel_data;
  logic                    issue;

  logic [NUM_SECTIONS-1:0] iss_start;
  logic [NUM_SECTIONS-1:0] iss_stop;
  logic                    iss_clear;

  logic [NUM_SECTIONS-1:0] keep_start;
  logic [NUM_SECTIONS-1:0] keep_stop;
  logic                    keep_clear;

  logic [NUM_SECTIONS-1:0] start_nxt;
  logic [NUM_SECTIONS-1:0] stop_nxt;
  logic [NUM_SECTIONS-1:0] first_nxt;
  logic                    clear_nxt;

  logic [NUM_SECTIONS-1:0] drop_start;
  logic [NUM_SECTIONS-1:0] drop_stop;
  logic                    drop_clear;
  logic [4:0]              drop_cnt;
  logic [SUM_W-1:0]        drop_sum;
  logic [DROP_W-1:0]       drop_nxt;

  // Fixed-priority arbitration: clear, then lowest section with anything pending.
  always_comb begin
    sel_clear    = pend_clear;
    sec_found    = 1'b0;
    sel_sec      = 3'd0;
    sel_is_start = 1'b0;
    for (int i = 0; i < NUM_SECTIONS; i++) begin
      if (!sec_found && (pend_start[i] || pend_stop[i])) begin
        sec_found    = 1'b1;
        sel_sec      = 3'(i);
        // With both pending, the order bit decides; otherwise whichever exists.
        sel_is_start = pend_start[i] && (!pend_stop[i] || start_first[i]);
      end
    end
    any_pend = pend_clear || sec_found;
  end

  // Address and data of the command that would launch this cycle.
  always_comb begin
    if (sel_clear) begin
      sel_addr = 5'd0;
      sel_data = 32'h0000_0001;
    end else begin
      sel_addr = {sel_sec, 1'b0, sel_is_start};
      sel_data = 32'h0000_0000;
    end
  end

  assign issue = (state == ST_IDLE) && any_pend;

  // One-hot of the selected section, used to retire its pending bit.
  always_comb begin
    sec_onehot = '0;
    for (int i = 0; i < NUM_SECTIONS; i++) begin
      sec_onehot[i] = (sel_sec == 3'(i));
    end
  end

  // Which pending bit is retired by a launch this cycle.
  always_comb begin
    iss_clear = issue && sel_clear;
    iss_start = '0;
    iss_stop  = '0;
    if (issue && !sel_clear) begin
      if (sel_is_start) begin
        iss_start = sec_onehot;
      end else begin
        iss_stop = sec_onehot;
      end
    end
  end

  // A pending bit that is being launched this cycle is free to re-capture,
  // so a pulse arriving with it is a new command rather than a drop.
  assign keep_start = pend_start & ~iss_start;
  assign keep_stop  = pend_stop  & ~iss_stop;
  assign keep_clear = pend_clear & ~iss_clear;

  assign drop_start = evt_start & keep_start;
  assign drop_stop  = evt_stop  & keep_stop;
  assign drop_clear = evt_clear & keep_clear;

  assign start_nxt  = keep_start | evt_start;
  assign stop_nxt   = keep_stop  | evt_stop;
  assign clear_nxt  = keep_clear | evt_clear;

  // Order bit: remember which of start/stop is older. A start and stop
  // captured together is a restart, so stop goes first.
  always_comb begin
    first_nxt = start_first;
    for (int i = 0; i < NUM_SECTIONS; i++) begin
      if (keep_start[i] && keep_stop[i]) begin
        first_nxt[i] = start_first[i];
      end else if (keep_start[i] && evt_stop[i]) begin
        first_nxt[i] = 1'b1;
      end else if (evt_start[i]) begin
        first_nxt[i] = 1'b0;
      end
    end
  end

  // Count every pulse lost this cycle and add it to the saturating total.
  always_comb begin
    drop_cnt = {4'd0, drop_clear};
    for (int i = 0; i < NUM_SECTIONS; i++) begin
      drop_cnt = drop_cnt + {4'd0, drop_start[i]} + {4'd0, drop_stop[i]};
    end
    drop_sum = SUM_W'(dropped_count) + SUM_W'(drop_cnt);
    if (drop_sum > SUM_W'({DROP_W{1'b1}})) begin
      drop_nxt = {DROP_W{1'b1}};
    end else begin
      drop_nxt = drop_sum[DROP_W-1:0];
    end
  end

  // Pending command capture and retirement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_start  <= '0;
      pend_stop   <= '0;
      start_first <= '0;
      pend_clear  <= 1'b0;
    end else begin
      pend_start  <= start_nxt;
      pend_stop   <= stop_nxt;
      start_first <= first_nxt;
      pend_clear  <= clear_nxt;
    end
  end

  // Saturating dropped-pulse counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropped_count <= '0;
    end else begin
      dropped_count <= drop_nxt;
    end
  end

  // Bus FSM: launch from IDLE, hold through stalls, return to IDLE on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      m_write         <= 1'b0;
      m_begintransfer <= 1'b0;
      m_address       <= 5'd0;
      m_writedata     <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state           <= ST_WRITE;
            m_write         <= 1'b1;
            m_begintransfer <= 1'b1;
            m_address       <= sel_addr;
            m_writedata     <= sel_data;
          end
        end
        ST_WRITE: begin
          m_begintransfer <= 1'b0;
          if (!m_waitrequest) begin
            state   <= ST_IDLE;
            m_write <= 1'b0;
          end
        end
        default: begin
          state           <= ST_IDLE;
          m_write         <= 1'b0;
          m_begintransfer <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE) || pend_clear || (|pend_start) || (|pend_stop);

endmodule

// File: tb/tb_nios2_ls_p_counter_trigger.sv
// Bench for nios2_ls_p_counter_trigger: directed scenarios with constant
// expectations plus randomized traffic against a queue-based model.
module tb_nios2_ls_p_counter_trigger;

  localparam int NS = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NS-1:0] evt_start = '0;
  logic [NS-1:0] evt_stop = '0;
  logic          evt_clear = 1'b0;
  logic [4:0]    m_address;
  logic          m_write;
  logic          m_begintransfer;
  logic [31:0]   m_writedata;
  logic          m_waitrequest = 1'b0;
  logic          busy;
  logic [DW-1:0] dropped_count;

  int checks = 0;
  int errors = 0;

  nios2_ls_p_counter_trigger #(.NUM_SECTIONS(NS), .DROP_W(DW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .evt_start       (evt_start),
    .evt_stop        (evt_stop),
    .evt_clear       (evt_clear),
    .m_address       (m_address),
    .m_write         (m_write),
    .m_begintransfer (m_begintransfer),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .busy            (busy),
    .dropped_count   (dropped_count)
  );

  always #5 clk = ~clk;

  // Reference model: per-section list of pending commands in capture order
  // (1 = start, 0 = stop), a clear flag, and the write currently on the bus.
  bit          mdl_write;
  bit          mdl_bt;
  logic [4:0]  mdl_addr;
  logic [31:0] mdl_data;
  bit          mdl_clear;
  int          qlen [NS];
  bit          qcmd [NS][2];
  logic [DW-1:0] mdl_drops;

  function automatic bit mdl_has(int n, bit c);
    return (qlen[n] > 0 && qcmd[n][0] == c) || (qlen[n] > 1 && qcmd[n][1] == c);
  endfunction

  function automatic bit mdl_busy();
    bit b;
    b = mdl_write || mdl_clear;
    for (int n = 0; n < NS; n++) if (qlen[n] > 0) b = 1'b1;
    return b;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_write = 1'b0;
      mdl_bt    = 1'b0;
      mdl_addr  = '0;
      mdl_data  = '0;
      mdl_clear = 1'b0;
      mdl_drops = '0;
      for (int n = 0; n < NS; n++) qlen[n] = 0;
    end else begin
      bit found;
      if (mdl_write) begin
        mdl_bt = 1'b0;
        if (!m_waitrequest) mdl_write = 1'b0;
      end else if (mdl_busy()) begin
        mdl_write = 1'b1;
        mdl_bt    = 1'b1;
        if (mdl_clear) begin
          mdl_clear = 1'b0;
          mdl_addr  = 5'd0;
          mdl_data  = 32'd1;
        end else begin
          found = 1'b0;
          for (int n = 0; n < NS; n++) begin
            if (!found && qlen[n] > 0) begin
              found      = 1'b1;
              mdl_addr   = 5'(4 * n + int'(qcmd[n][0]));
              mdl_data   = 32'd0;
              qcmd[n][0] = qcmd[n][1];
              qlen[n]    = qlen[n] - 1;
            end
          end
        end
      end
      if (evt_clear) begin
        if (mdl_clear) begin
          if (mdl_drops != '1) mdl_drops = mdl_drops + 1'b1;
        end else begin
          mdl_clear = 1'b1;
        end
      end
      for (int n = 0; n < NS; n++) begin
        // stop before start so a same-cycle pair becomes a restart
        if (evt_stop[n]) begin
          if (mdl_has(n, 1'b0)) begin
            if (mdl_drops != '1) mdl_drops = mdl_drops + 1'b1;
          end else begin
            qcmd[n][qlen[n]] = 1'b0;
            qlen[n] = qlen[n] + 1;
          end
        end
        if (evt_start[n]) begin
          if (mdl_has(n, 1'b1)) begin
            if (mdl_drops != '1) mdl_drops = mdl_drops + 1'b1;
          end else begin
            qcmd[n][qlen[n]] = 1'b1;
            qlen[n] = qlen[n] + 1;
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset_n       = 1'b0;
    evt_start     = '0;
    evt_stop      = '0;
    evt_clear     = 1'b0;
    m_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    evt_start = '0; evt_stop = '0; evt_clear = 1'b0; m_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (m_write !== 1'b0 || m_begintransfer !== 1'b0 || m_address !== 5'd0 ||
        m_writedata !== 32'd0 || busy !== 1'b0 || dropped_count !== '0) begin
      errors++;
      $display("FAIL reset_state: write=%b bt=%b addr=%0d data=%h busy=%b drops=%0d, want all 0",
               m_write, m_begintransfer, m_address, m_writedata, busy, dropped_count);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (m_write !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: write=%b busy=%b, want 0 0", m_write, busy);
    end
  endtask

  task automatic test_single_start();
    do_reset();
    evt_start[2] = 1'b1;
    @(negedge clk);
    evt_start = '0;
    checks++;
    if (m_write !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_c1: write=%b busy=%b, want 0 1", m_write, busy);
    end
    @(negedge clk);
    checks++;
    if (m_write !== 1'b1 || m_begintransfer !== 1'b1 || m_address !== 5'd9 || m_writedata !== 32'd0) begin
      errors++;
      $display("FAIL single_c2: write=%b bt=%b addr=%0d data=%h, want 1 1 9 0",
               m_write, m_begintransfer, m_address, m_writedata);
    end
    @(negedge clk);
    checks++;
    if (m_write !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_c3: write=%b busy=%b, want 0 0", m_write, busy);
    end
  endtask

  task automatic test_stall();
    do_reset();
    m_waitrequest = 1'b1;
    evt_stop[1] = 1'b1;
    @(negedge clk);
    evt_stop = '0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (m_write !== 1'b1 || m_address !== 5'd4 || m_writedata !== 32'd0 ||
          m_begintransfer !== (k == 2) || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: write=%b addr=%0d data=%h bt=%b busy=%b, want 1 4 0 %0d 1",
                 k, m_write, m_address, m_writedata, m_begintransfer, busy, (k == 2));
      end
      if (k == 5) m_waitrequest = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (m_write !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: write=%b busy=%b, want 0 0", m_write, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_start[0] = 1'b1;
    evt_start[1] = 1'b1;
    @(negedge clk);
    evt_start = '0;
    @(negedge clk);
    checks++;
    if (m_write !== 1'b1 || m_address !== 5'd1) begin
      errors++;
      $display("FAIL b2b_first: write=%b addr=%0d, want 1 1", m_write, m_address);
    end
    @(negedge clk);
    checks++;
    if (m_write !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: write=%b busy=%b, want 0 1", m_write, busy);
    end
    @(negedge clk);
    checks++;
    if (m_write !== 1'b1 || m_begintransfer !== 1'b1 || m_address !== 5'd5) begin
      errors++;
      $display("FAIL b2b_second: write=%b bt=%b addr=%0d, want 1 1 5", m_write, m_begintransfer, m_address);
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0]  wa [8];
    logic [31:0] wd [8];
    int nw;
    nw = 0;
    do_reset();
    evt_clear = 1'b1; evt_start[0] = 1'b1; evt_stop[0] = 1'b1;
    @(negedge clk);
    evt_clear = 1'b0; evt_start = '0; evt_stop = '0;
    for (int k = 0; k < 12; k++) begin
      if (m_write === 1'b1 && m_waitrequest === 1'b0 && nw < 8) begin
        wa[nw] = m_address; wd[nw] = m_writedata; nw++;
      end
      @(negedge clk);
    end
    checks++;
    if (nw != 3) begin
      errors++;
      $display("FAIL simul_count: writes=%0d, want 3", nw);
    end else begin
      checks++;
      if (wa[0] !== 5'd0 || wd[0] !== 32'd1 || wa[1] !== 5'd0 || wd[1] !== 32'd0 ||
          wa[2] !== 5'd1 || wd[2] !== 32'd0) begin
        errors++;
        $display("FAIL simul_seq: got %0d/%0h %0d/%0h %0d/%0h, want 0/1 0/0 1/0",
                 wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
      end
    end
  endtask

  task automatic test_ordering();
    logic [4:0] wa [8];
    int nw;
    nw = 0;
    do_reset();
    m_waitrequest = 1'b1;
    evt_start[7] = 1'b1;
    @(negedge clk); evt_start = '0;
    @(negedge clk); evt_start[3] = 1'b1;
    @(negedge clk); evt_start = '0; evt_stop[3] = 1'b1;
    @(negedge clk); evt_stop = '0;
    @(negedge clk); m_waitrequest = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (m_write === 1'b1 && m_waitrequest === 1'b0 && nw < 8) begin
        wa[nw] = m_address; nw++;
      end
      @(negedge clk);
    end
    checks++;
    if (nw != 3 || wa[0] !== 5'd29 || wa[1] !== 5'd13 || wa[2] !== 5'd12) begin
      errors++;
      $display("FAIL order_seq: writes=%0d first=%0d %0d %0d, want 3 writes 29 13 12",
               nw, wa[0], wa[1], wa[2]);
    end
  endtask

  task automatic test_drop();
    logic [4:0] wa [8];
    int nw;
    nw = 0;
    do_reset();
    m_waitrequest = 1'b1;
    evt_start[7] = 1'b1;
    @(negedge clk); evt_start = '0;
    @(negedge clk); evt_start[5] = 1'b1;
    @(negedge clk); evt_start = '0;
    @(negedge clk); evt_start[5] = 1'b1;
    @(negedge clk); evt_start = '0;
    checks++;
    if (dropped_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_one: dropped=%0d, want 1", dropped_count);
    end
    m_waitrequest = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (m_write === 1'b1 && m_waitrequest === 1'b0 && nw < 8) begin
        wa[nw] = m_address; nw++;
      end
      @(negedge clk);
    end
    checks++;
    if (nw != 2 || wa[1] !== 5'd21 || dropped_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_writes: writes=%0d second=%0d dropped=%0d, want 2 21 1",
               nw, wa[1], dropped_count);
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    m_waitrequest = 1'b1;
    // Held high: captured, then launched (re-captured), then dropped every cycle.
    evt_start[5] = 1'b1;
    repeat (65536) @(negedge clk);
    checks++;
    if (dropped_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL drop_near_sat: dropped=%h, want fffe", dropped_count);
    end
    repeat (7) @(negedge clk);
    evt_start = '0;
    checks++;
    if (dropped_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_sat: dropped=%h, want ffff", dropped_count);
    end
  endtask

  task automatic test_reset_mid_write();
    int bad;
    bad = 0;
    do_reset();
    m_waitrequest = 1'b1;
    evt_stop[1] = 1'b1;
    @(negedge clk); evt_stop = '0; evt_clear = 1'b1; evt_start[4] = 1'b1;
    @(negedge clk); evt_clear = 1'b0; evt_start = '0;
    checks++;
    if (m_write !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: write=%b, want 1", m_write);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (m_write !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop: write=%b busy=%b, want 0 0", m_write, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_waitrequest = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m_write !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_after: %0d cycles with write or busy set, want 0", bad);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      checks++;
      if (m_write !== mdl_write || m_begintransfer !== mdl_bt || busy !== mdl_busy() ||
          dropped_count !== mdl_drops ||
          (mdl_write && (m_address !== mdl_addr || m_writedata !== mdl_data))) begin
        errors++;
        if (errors < 20)
          $display("FAIL random_cyc%0d: w=%b bt=%b a=%0d d=%h busy=%b dr=%0d, want w=%b bt=%b a=%0d d=%h busy=%b dr=%0d",
                   cyc, m_write, m_begintransfer, m_address, m_writedata, busy, dropped_count,
                   mdl_write, mdl_bt, mdl_addr, mdl_data, mdl_busy(), mdl_drops);
      end
      if (cyc < 3950) begin
        evt_start     = NS'($urandom) & NS'($urandom) & NS'($urandom);
        evt_stop      = NS'($urandom) & NS'($urandom) & NS'($urandom);
        evt_clear     = ($urandom_range(0, 15) == 0);
        m_waitrequest = ($urandom_range(0, 2) == 0);
      end else begin
        evt_start = '0; evt_stop = '0; evt_clear = 1'b0; m_waitrequest = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_start();
    test_stall();
    test_back_to_back();
    test_simultaneous();
    test_ordering();
    test_drop();
    test_reset_mid_write();
    test_random();
    test_drop_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
